// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end.
// Provides the architectural vectors, the kernel-mode PC bit, the $k0 register
// index, the next-PC select encoding and the bit-31-preserving PC increment.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int unsigned KBIT = 31;
  localparam int unsigned K0   = 26;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_REDIR,
    SEL_IRQ,
    SEL_EXC
  } pc_sel_e;

  // PC+4 with the carry out of bit 30 dropped so the mode bit never flips.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return {pc[KBIT], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of all fetch-stage signals except clock and reset.
//   imem_addr/imem_data : combinational instruction ROM port
//   stall/flush         : hazard unit controls
//   redirect_*          : taken branch/jump/jr from later stages
//   irq, exc_req, exc_pc_plus4 : interrupt and decode-exception requests
//   if_instr/if_pc_plus4/if_valid : IF/ID pipeline register
//   epc_we/epc_data     : $k0 write of the handler return address
//   kernel_mode         : current PC[31]
// master = the fetch stage, slave = its surroundings.
interface if_stage_if;
  import cpu_pkg::*;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic        redirect_jr;
  logic [31:0] redirect_pc;
  logic        irq;
  logic        exc_req;
  logic [31:0] exc_pc_plus4;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        epc_we;
  logic [31:0] epc_data;
  logic        kernel_mode;

  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  flush,
    input  redirect_valid,
    input  redirect_jr,
    input  redirect_pc,
    input  irq,
    input  exc_req,
    input  exc_pc_plus4,
    output if_instr,
    output if_pc_plus4,
    output if_valid,
    output epc_we,
    output epc_data,
    output kernel_mode
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output flush,
    output redirect_valid,
    output redirect_jr,
    output redirect_pc,
    output irq,
    output exc_req,
    output exc_pc_plus4,
    input  if_instr,
    input  if_pc_plus4,
    input  if_valid,
    input  epc_we,
    input  epc_data,
    input  kernel_mode
  );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC arbiter.
// Inputs : current pc, stall, redirect (valid/jr/pc), irq, exc_req, exc_pc_plus4.
// Outputs: sel (which source wins), target (next PC, word aligned), epc_data
//          (handler return address, meaningful for SEL_IRQ/SEL_EXC).
// Priority: exception > redirect > interrupt > stall > sequential.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter logic [31:0] IrqVec = IRQ_VEC,
  parameter logic [31:0] ExcVec = EXC_VEC
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic        redirect_jr,
  input  logic [31:0] redirect_pc,
  input  logic        irq,
  input  logic        exc_req,
  input  logic [31:0] exc_pc_plus4,
  output pc_sel_e     sel,
  output logic [31:0] target,
  output logic [31:0] epc_data
);

  logic        kernel;
  logic [31:0] seq_pc;
  logic        redir_k;
  logic        unused_redirect_lsbs;

  assign kernel  = pc[KBIT];
  assign seq_pc  = pc_inc(pc);
  // A jr issued from user space may not land in kernel space.
  assign redir_k = redirect_pc[KBIT] & ~(redirect_jr & ~kernel);
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    sel      = SEL_SEQ;
    target   = seq_pc;
    epc_data = seq_pc;
    if (exc_req && !kernel) begin
      sel      = SEL_EXC;
      target   = ExcVec;
      epc_data = exc_pc_plus4;
    end else if (redirect_valid) begin
      sel    = SEL_REDIR;
      target = {redir_k, redirect_pc[30:2], 2'b00};
    end else if (irq && !kernel && !stall) begin
      // Return address skips the discarded slot; the handler backs up by 4.
      sel    = SEL_IRQ;
      target = IrqVec;
    end else if (stall) begin
      sel    = SEL_HOLD;
      target = pc;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and the
// one-cycle $k0 (epc) write pulse.
// Ports: clk, reset (async, active low), bus (if_stage_if.master) carrying the
// ROM port, hazard controls, redirect/irq/exception requests and IF/ID outputs.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] ResetPc = RESET_PC,
  parameter logic [31:0] IrqVec  = IRQ_VEC,
  parameter logic [31:0] ExcVec  = EXC_VEC,
  parameter logic [31:0] NopWord = NOP_WORD
) (
  input  logic          clk,
  input  logic          reset,
  if_stage_if.master    bus
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic        epc_we_q;
  logic [31:0] epc_data_q;

  pc_sel_e     sel;
  logic [31:0] target;
  logic [31:0] epc_next;
  logic [31:0] seq_pc;

  assign seq_pc = pc_inc(pc_q);

  pc_next_sel #(
    .IrqVec (IrqVec),
    .ExcVec (ExcVec)
  ) u_pc_next_sel (
    .pc             (pc_q),
    .stall          (bus.stall),
    .redirect_valid (bus.redirect_valid),
    .redirect_jr    (bus.redirect_jr),
    .redirect_pc    (bus.redirect_pc),
    .irq            (bus.irq),
    .exc_req        (bus.exc_req),
    .exc_pc_plus4   (bus.exc_pc_plus4),
    .sel            (sel),
    .target         (target),
    .epc_data       (epc_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= ResetPc;
      instr_q    <= NopWord;
      pc4_q      <= 32'h0;
      valid_q    <= 1'b0;
      epc_we_q   <= 1'b0;
      epc_data_q <= 32'h0;
    end else begin
      epc_we_q <= 1'b0;
      if (sel != SEL_HOLD) begin
        pc_q <= target;
      end
      if (sel == SEL_SEQ && !bus.flush) begin
        instr_q <= bus.imem_data;
        pc4_q   <= seq_pc;
        valid_q <= 1'b1;
      end else if (sel != SEL_HOLD || bus.flush) begin
        // Bubble still records the PC+4 of the slot it replaces.
        instr_q <= NopWord;
        pc4_q   <= seq_pc;
        valid_q <= 1'b0;
      end
      if (sel == SEL_IRQ || sel == SEL_EXC) begin
        epc_we_q   <= 1'b1;
        epc_data_q <= epc_next;
      end
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.kernel_mode = pc_q[KBIT];
  assign bus.if_instr    = instr_q;
  assign bus.if_pc_plus4 = pc4_q;
  assign bus.if_valid    = valid_q;
  assign bus.epc_we      = epc_we_q;
  assign bus.epc_data    = epc_data_q;

endmodule
